timeout_timer: RTL and testbench
================================

TIMEOUT_TIMER -- requirements
Module: timeout_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, the width of the time count.
REQ-002 The block SHALL have parameter TIMEOUT, default 3'b110, the terminal count value (0 < TIMEOUT < 2**WIDTH).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to (re)start timing from zero.
REQ-006 The block SHALL have port stop, input, 1, a one-cycle request to abort timing.
REQ-007 The block SHALL have port tick, input, 1, the count enable; one increment per cycle it is high in RUN.
REQ-008 The block SHALL have port reload, input, 1: 1 = periodic (stay in RUN after expiry), 0 = one-shot.
REQ-009 The block SHALL have port clr, input, 1, a one-cycle clear of overrun and expire_cnt.
REQ-010 The block SHALL have port expire_ready, input, 1, the consumer acceptance of the expiry event.
REQ-011 The block SHALL have port time_q, output, WIDTH, the registered current time count.
REQ-012 The block SHALL have port busy, output, 1, high while the FSM is in RUN.
REQ-013 The block SHALL have port expire_valid, output, 1, the expiry event pending.
REQ-014 The block SHALL have port expire_cnt, output, 4, the number of expiries, saturating at 15.
REQ-015 The block SHALL have port overrun, output, 1, sticky: an expiry occurred while a previous one was still unaccepted.

Function
REQ-016 FSM SHALL have two states: IDLE and RUN; busy = (state == RUN), registered.
REQ-017 IDLE: time_q SHALL hold 0; tick SHALL be ignored; start -> RUN with time_q = 0.
REQ-018 RUN, tick=1, time_q != TIMEOUT: time_q SHALL become time_q+1 (modulo 2**WIDTH) next cycle.
REQ-019 RUN, tick=1, time_q == TIMEOUT: time_q SHALL become 0, expire_valid SHALL be 1 next cycle, expire_cnt SHALL increment unless already 15, and state SHALL go to IDLE if reload=0 or stay RUN if reload=1.
REQ-020 RUN, tick=0: time_q SHALL hold.
REQ-021 stop in RUN SHALL force IDLE and time_q = 0 next cycle, with no expiry generated even if tick=1 and time_q == TIMEOUT.
REQ-022 start and stop in the same cycle: stop SHALL win.
REQ-023 start in RUN SHALL restart: time_q = 0 next cycle and tick SHALL be ignored that cycle.
REQ-024 Handshake: expire_valid SHALL stay high until a cycle with expire_ready=1, then drop next cycle unless a new expiry occurs in that same cycle (it then stays 1, no overrun).
REQ-025 New expiry while expire_valid=1 and expire_ready=0: overrun SHALL be set, expire_valid SHALL stay 1, and expire_cnt SHALL still increment.
REQ-026 clr SHALL zero overrun and expire_cnt next cycle; a simultaneous expiry SHALL win (expire_cnt = 1, overrun set per REQ-025 rules).
REQ-027 stop and start SHALL NOT affect expire_valid, expire_cnt or overrun.
REQ-028 All outputs SHALL be registered; expiry is visible 1 cycle after the terminal tick.

Reset
REQ-029 rst_n low SHALL immediately force state = IDLE, time_q = 0, busy = 0, expire_valid = 0, expire_cnt = 0 and overrun = 0, independent of clk.
REQ-030 Reset asserted mid-RUN or with an event pending SHALL discard all progress; operation resumes only on start after rst_n is high.

Structure
REQ-031 Shared package SHALL hold the state encodings (IDLE = 1'b0, RUN = 1'b1), the default TIMEOUT, and the expire_cnt width/saturation value 15.
REQ-032 The next-time calculation (time != TIMEOUT ? time+1 : 0, plus a wrap flag) SHALL be a combinational sub-module time_next_calc, instantiated once.

Verification
REQ-033 The bench SHALL cover: reset, start, tick held high, reload=1 -> time_q 0,1..6,0 repeating, expire_valid high 1 cycle after each time_q = 6 tick, expire_cnt counting 1, 2, 3.
REQ-034 The bench SHALL cover: reload=0, tick high, expire_ready=1 -> one expiry, busy=0 after it, time_q stays 0, expire_valid a single-cycle pulse.
REQ-035 The bench SHALL cover: expire_ready=0 across two expiries with reload=1 -> overrun=1, expire_valid held, expire_cnt=2; then clr -> both 0 and expire_valid still 1 until ready.
REQ-036 The bench SHALL cover: start+stop same cycle in IDLE -> stays IDLE; stop at time_q=6 with tick=1 -> no expiry, time_q=0.
REQ-037 The bench SHALL cover: rst_n dropped mid-count at time_q=4 with expire_valid=1 -> all outputs 0 asynchronously (before the next clk edge).
REQ-038 The bench SHALL cover: 16 expiries with ready=1 -> expire_cnt saturates at 15, overrun stays 0.

Source files
------------

// File: rtl/timeout_timer_pkg.sv
// Timeout timer shared types and constants.
// State encodings, default terminal count, expiry counter sizing.
package timeout_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned TIMEOUT_DEF = 6;
  localparam int unsigned CNT_W       = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

endpackage

// File: rtl/timeout_timer_if.sv
// Expiry event bundle: valid/ready handshake
// plus the expiry count and sticky overrun flag.
interface timeout_timer_if;
  import timeout_timer_pkg::*;

  logic             expire_valid;
  logic             expire_ready;
  logic [CNT_W-1:0] expire_cnt;
  logic             overrun;

  modport master (
    output expire_valid,
    output expire_cnt,
    output overrun,
    input  expire_ready
  );

  modport slave (
    input  expire_valid,
    input  expire_cnt,
    input  overrun,
    output expire_ready
  );

endinterface

// File: rtl/timeout_timer_time_next_calc.sv
// Next time value: increment, or wrap to zero
// at the terminal count with a wrap flag.
module time_next_calc #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned TIMEOUT = 6
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TO = WIDTH'(TIMEOUT);

  // terminal count detect and successor
  always_comb begin
    wrap = (cur == TO);
    nxt  = wrap ? '0 : cur + 1'b1;
  end

endmodule

// File: rtl/timeout_timer.sv
// Timeout timer: IDLE/RUN FSM, tick-driven count,
// expiry event with handshake, count and overrun.
module timeout_timer
  import timeout_timer_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             tick,
  input  logic             reload,
  input  logic             clr,
  output logic [WIDTH-1:0] time_q,
  output logic             busy,
  timeout_timer_if.master  ev
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] time_d;
  logic             ev_valid_q, ev_valid_d;
  logic [CNT_W-1:0] ev_cnt_q, ev_cnt_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] time_nxt;
  logic             wrap;
  logic             expire;

  time_next_calc #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) u_next (
    .cur  (time_q),
    .nxt  (time_nxt),
    .wrap (wrap)
  );

  // FSM next state and time count
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    expire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        time_d = '0;
        if (start && !stop)
          state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          time_d  = '0;
        end else if (start) begin
          time_d = '0;
        end else if (tick) begin
          time_d = time_nxt;
          if (wrap) begin
            expire = 1'b1;
            if (!reload)
              state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        time_d  = '0;
      end
    endcase
  end

  // expiry handshake, counter and overrun
  always_comb begin
    ev_valid_d = ev_valid_q;
    ev_cnt_d   = clr ? '0 : ev_cnt_q;
    ovr_d      = clr ? 1'b0 : ovr_q;
    if (ev_valid_q && ev.expire_ready)
      ev_valid_d = 1'b0;
    if (expire) begin
      ev_valid_d = 1'b1;
      if (ev_valid_q && !ev.expire_ready)
        ovr_d = 1'b1;
      if (clr)
        ev_cnt_d = CNT_W'(1);
      else if (ev_cnt_q != CNT_MAX)
        ev_cnt_d = ev_cnt_q + 1'b1;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      time_q     <= '0;
      ev_valid_q <= 1'b0;
      ev_cnt_q   <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      ev_valid_q <= ev_valid_d;
      ev_cnt_q   <= ev_cnt_d;
      ovr_q      <= ovr_d;
    end
  end

  assign busy            = (state_q == RUN);
  assign ev.expire_valid = ev_valid_q;
  assign ev.expire_cnt   = ev_cnt_q;
  assign ev.overrun      = ovr_q;

endmodule

// File: tb/tb_timeout_timer.sv
// Directed bench for timeout_timer.
// Hand-computed expectations, immediate assertions.
module tb_timeout_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, tick, reload, clr;
  logic [2:0] time_q;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  timeout_timer_if ev_if ();

  timeout_timer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .stop   (stop),
    .tick   (tick),
    .reload (reload),
    .clr    (clr),
    .time_q (time_q),
    .busy   (busy),
    .ev     (ev_if.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] t,
                         input logic b, input logic v,
                         input logic [3:0] c, input logic o);
    chk({tag, ".time"}, {5'd0, time_q}, {5'd0, t});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
    chk({tag, ".valid"}, {7'd0, ev_if.expire_valid}, {7'd0, v});
    chk({tag, ".cnt"}, {4'd0, ev_if.expire_cnt}, {4'd0, c});
    chk({tag, ".ovr"}, {7'd0, ev_if.overrun}, {7'd0, o});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; stop = 0; tick = 0; reload = 0; clr = 0;
    ev_if.expire_ready = 1'b0;
    step(); step();
    chk_all("reset", 3'd0, 0, 0, 4'd0, 0);
    rst_n = 1'b1;
    tick = 1;
    step();
    chk_all("idle_tick", 3'd0, 0, 0, 4'd0, 0);

    // periodic: 0,1..6,0 with single-cycle expiry
    reload = 1; ev_if.expire_ready = 1; start = 1;
    step();
    chk_all("start", 3'd0, 1, 0, 4'd0, 0);
    start = 0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 7; k++) begin
        step();
        chk("per.time", {5'd0, time_q}, 8'(k % 7));
        chk("per.valid", {7'd0, ev_if.expire_valid}, {7'd0, k == 7});
        chk("per.busy", {7'd0, busy}, 8'd1);
      end
      chk("per.cnt", {4'd0, ev_if.expire_cnt}, 8'(p + 1));
    end
    stop = 1;
    step();
    chk_all("per_stop", 3'd0, 0, 0, 4'd3, 0);
    stop = 0;

    // one-shot
    clr = 1;
    step();
    chk_all("clr", 3'd0, 0, 0, 4'd0, 0);
    clr = 0; reload = 0; start = 1;
    step();
    start = 0;
    for (int k = 1; k <= 6; k++) step();
    chk_all("os_at6", 3'd6, 1, 0, 4'd0, 0);
    step();
    chk_all("os_exp", 3'd0, 0, 1, 4'd1, 0);
    step();
    chk_all("os_after", 3'd0, 0, 0, 4'd1, 0);
    step();
    chk_all("os_idle", 3'd0, 0, 0, 4'd1, 0);

    // overrun with ready low, then clr
    ev_if.expire_ready = 0; reload = 1; clr = 1; start = 1;
    step();
    chk_all("ovr_start", 3'd0, 1, 0, 4'd0, 0);
    clr = 0; start = 0;
    for (int k = 1; k <= 7; k++) step();
    chk_all("ovr_exp1", 3'd0, 1, 1, 4'd1, 0);
    for (int k = 1; k <= 7; k++) step();
    chk_all("ovr_exp2", 3'd0, 1, 1, 4'd2, 1);
    stop = 1; clr = 1;
    step();
    chk_all("ovr_clr", 3'd0, 0, 1, 4'd0, 0);
    stop = 0; clr = 0;
    step();
    chk_all("ovr_hold", 3'd0, 0, 1, 4'd0, 0);
    ev_if.expire_ready = 1;
    step();
    chk_all("ovr_ack", 3'd0, 0, 0, 4'd0, 0);

    // start+stop in IDLE, stop at terminal count
    start = 1; stop = 1;
    step();
    chk_all("ss_idle", 3'd0, 0, 0, 4'd0, 0);
    stop = 0;
    step();
    start = 0;
    for (int k = 1; k <= 6; k++) step();
    chk_all("stop6_pre", 3'd6, 1, 0, 4'd0, 0);
    stop = 1;
    step();
    chk_all("stop6", 3'd0, 0, 0, 4'd0, 0);
    stop = 0;
    step();
    chk_all("stop6_post", 3'd0, 0, 0, 4'd0, 0);

    // restart in RUN ignores tick
    start = 1;
    step();
    start = 0;
    step(); step();
    chk("rs_pre", {5'd0, time_q}, 8'd2);
    start = 1;
    step();
    chk_all("restart", 3'd0, 1, 0, 4'd0, 0);
    start = 0;

    // async reset mid-count with event pending
    ev_if.expire_ready = 0;
    for (int k = 1; k <= 11; k++) step();
    chk_all("ar_pre", 3'd4, 1, 1, 4'd1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("ar_async", 3'd0, 0, 0, 4'd0, 0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk_all("ar_post", 3'd0, 0, 0, 4'd0, 0);

    // saturation over 16 expiries
    ev_if.expire_ready = 1; start = 1;
    step();
    start = 0;
    for (int p = 0; p < 16; p++) begin
      for (int k = 1; k <= 7; k++) step();
      chk("sat.cnt", {4'd0, ev_if.expire_cnt}, 8'((p < 15) ? p + 1 : 15));
    end
    chk_all("sat_end", 3'd0, 1, 1, 4'd15, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
